// File: rtl/rv32i_types.sv
// Shared CPU type package: memory arbiter state and port-select encodings.
package rv32i_types;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_L,
        RESP_I,
        RESP_L
    } arb_state_t;

    typedef enum logic {
        ARB_I,
        ARB_L
    } arb_port_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Memory port bundle: request held until a one-cycle resp pulse.
// master = initiator side, slave = responder side.
interface cpu_mem_arbiter_if #(
    parameter int width = 32
);
    logic                 read;
    logic                 write;
    logic [width/8-1:0]   byte_enable;
    logic [width-1:0]     address;
    logic [width-1:0]     wdata;
    logic                 resp;
    logic [width-1:0]     rdata;

    modport master (
        output read, write, byte_enable, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, byte_enable, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Two-initiator memory arbiter: fetch and LSQ ports share one downstream
// memory port, one transaction at a time, round-robin on ties.
module cpu_mem_arbiter
    import rv32i_types::*;
(
    input logic               clk,
    input logic               rst,
    cpu_mem_arbiter_if.slave  i_mem,
    cpu_mem_arbiter_if.slave  lsq_mem,
    cpu_mem_arbiter_if.master mem
);

    arb_state_t state;
    arb_port_t  last_grant;

    logic i_pend;
    logic l_pend;
    logic grant_i;

    // A port is pending on read or write; fetch wins a tie only if LSQ won last.
    always_comb begin
        i_pend  = i_mem.read | i_mem.write;
        l_pend  = lsq_mem.read | lsq_mem.write;
        grant_i = i_pend && (!l_pend || (last_grant == ARB_L));
    end

    // Arbitration FSM; all port-facing and downstream outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            last_grant          <= ARB_I;
            mem.read            <= 1'b0;
            mem.write           <= 1'b0;
            mem.byte_enable     <= '0;
            mem.address         <= '0;
            mem.wdata           <= '0;
            i_mem.resp          <= 1'b0;
            i_mem.rdata         <= '0;
            lsq_mem.resp        <= 1'b0;
            lsq_mem.rdata       <= '0;
        end else begin
            i_mem.resp   <= 1'b0;
            lsq_mem.resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        // Read and write together is treated as a write.
                        mem.read        <= i_mem.read & ~i_mem.write;
                        mem.write       <= i_mem.write;
                        mem.byte_enable <= i_mem.byte_enable;
                        mem.address     <= i_mem.address;
                        mem.wdata       <= i_mem.wdata;
                        last_grant      <= ARB_I;
                        state           <= BUSY_I;
                    end else if (l_pend) begin
                        mem.read        <= lsq_mem.read & ~lsq_mem.write;
                        mem.write       <= lsq_mem.write;
                        mem.byte_enable <= lsq_mem.byte_enable;
                        mem.address     <= lsq_mem.address;
                        mem.wdata       <= lsq_mem.wdata;
                        last_grant      <= ARB_L;
                        state           <= BUSY_L;
                    end
                end
                BUSY_I: begin
                    if (mem.resp) begin
                        mem.read    <= 1'b0;
                        mem.write   <= 1'b0;
                        i_mem.resp  <= 1'b1;
                        i_mem.rdata <= mem.rdata;
                        state       <= RESP_I;
                    end
                end
                BUSY_L: begin
                    if (mem.resp) begin
                        mem.read      <= 1'b0;
                        mem.write     <= 1'b0;
                        lsq_mem.resp  <= 1'b1;
                        lsq_mem.rdata <= mem.rdata;
                        state         <= RESP_L;
                    end
                end
                // The finished initiator still holds its request here, so ignore it.
                RESP_I, RESP_L: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter.
module tb_cpu_mem_arbiter;

    logic clk;
    logic rst;
    int   vec;
    int   miss;

    cpu_mem_arbiter_if #(.width(32)) i_bus ();
    cpu_mem_arbiter_if #(.width(32)) l_bus ();
    cpu_mem_arbiter_if #(.width(32)) m_bus ();

    cpu_mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_mem   (i_bus),
        .lsq_mem (l_bus),
        .mem     (m_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse downstream resp for one cycle; returns positioned in the RESP cycle.
    task automatic mem_respond(input logic [31:0] d);
        m_bus.resp  = 1'b1;
        m_bus.rdata = d;
        tick();
        m_bus.resp  = 1'b0;
        m_bus.rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec++; if (m_bus.read !== 1'b0) begin miss++; $display("FAIL rst_mem_read: got %b want 0", m_bus.read); end
        vec++; if (m_bus.write !== 1'b0) begin miss++; $display("FAIL rst_mem_write: got %b want 0", m_bus.write); end
        vec++; if (m_bus.byte_enable !== 4'h0) begin miss++; $display("FAIL rst_mem_be: got %h want 0", m_bus.byte_enable); end
        vec++; if (m_bus.address !== 32'h0) begin miss++; $display("FAIL rst_mem_addr: got %h want 0", m_bus.address); end
        vec++; if (m_bus.wdata !== 32'h0) begin miss++; $display("FAIL rst_mem_wdata: got %h want 0", m_bus.wdata); end
        vec++; if (i_bus.resp !== 1'b0 || l_bus.resp !== 1'b0) begin miss++; $display("FAIL rst_resp: got i=%b l=%b want 0 0", i_bus.resp, l_bus.resp); end
        vec++; if (i_bus.rdata !== 32'h0 || l_bus.rdata !== 32'h0) begin miss++; $display("FAIL rst_rdata: got i=%h l=%h want 0 0", i_bus.rdata, l_bus.rdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        i_bus.read    = 1'b1;
        i_bus.address = 32'h60;
        i_bus.byte_enable = 4'hf;
        tick();
        vec++; if (m_bus.read !== 1'b1 || m_bus.write !== 1'b0) begin miss++; $display("FAIL fetch_req: got r=%b w=%b want 1 0", m_bus.read, m_bus.write); end
        vec++; if (m_bus.address !== 32'h60) begin miss++; $display("FAIL fetch_addr: got %h want 00000060", m_bus.address); end
        tick();
        tick();
        vec++; if (m_bus.read !== 1'b1 || i_bus.resp !== 1'b0) begin miss++; $display("FAIL fetch_busy: got r=%b resp=%b want 1 0", m_bus.read, i_bus.resp); end
        mem_respond(32'h00000013);
        vec++; if (i_bus.resp !== 1'b1) begin miss++; $display("FAIL fetch_resp: got %b want 1", i_bus.resp); end
        vec++; if (i_bus.rdata !== 32'h00000013) begin miss++; $display("FAIL fetch_rdata: got %h want 00000013", i_bus.rdata); end
        vec++; if (l_bus.resp !== 1'b0) begin miss++; $display("FAIL fetch_lsq_quiet: got %b want 0", l_bus.resp); end
        vec++; if (m_bus.read !== 1'b0) begin miss++; $display("FAIL fetch_mem_clear: got %b want 0", m_bus.read); end
        tick();
        i_bus.read = 1'b0;
        vec++; if (i_bus.resp !== 1'b0) begin miss++; $display("FAIL fetch_resp_width: got %b want 0", i_bus.resp); end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        i_bus.read        = 1'b1;
        i_bus.address     = 32'h100;
        l_bus.write       = 1'b1;
        l_bus.address     = 32'h2000;
        l_bus.wdata       = 32'hDEADBEEF;
        l_bus.byte_enable = 4'b0011;
        tick();
        vec++; if (m_bus.write !== 1'b1 || m_bus.read !== 1'b0) begin miss++; $display("FAIL tie1_lsq_req: got r=%b w=%b want 0 1", m_bus.read, m_bus.write); end
        vec++; if (m_bus.address !== 32'h2000) begin miss++; $display("FAIL tie1_addr: got %h want 00002000", m_bus.address); end
        vec++; if (m_bus.byte_enable !== 4'b0011) begin miss++; $display("FAIL tie1_be: got %b want 0011", m_bus.byte_enable); end
        vec++; if (m_bus.wdata !== 32'hDEADBEEF) begin miss++; $display("FAIL tie1_wdata: got %h want deadbeef", m_bus.wdata); end
        mem_respond(32'h0);
        vec++; if (l_bus.resp !== 1'b1 || i_bus.resp !== 1'b0) begin miss++; $display("FAIL tie1_resp: got l=%b i=%b want 1 0", l_bus.resp, i_bus.resp); end
        tick();
        l_bus.write = 1'b0;
        tick();
        vec++; if (m_bus.read !== 1'b1 || m_bus.address !== 32'h100) begin miss++; $display("FAIL tie1_fetch_next: got r=%b a=%h want 1 00000100", m_bus.read, m_bus.address); end
        mem_respond(32'hCAFE0001);
        vec++; if (i_bus.resp !== 1'b1 || i_bus.rdata !== 32'hCAFE0001) begin miss++; $display("FAIL tie1_fetch_resp: got r=%b d=%h want 1 cafe0001", i_bus.resp, i_bus.rdata); end
        vec++; if (l_bus.resp !== 1'b0) begin miss++; $display("FAIL tie1_lsq_quiet: got %b want 0", l_bus.resp); end
        tick();
        // Second tie: last grant was fetch, so LSQ must win again.
        i_bus.address = 32'h104;
        l_bus.read    = 1'b1;
        l_bus.address = 32'h3000;
        tick();
        vec++; if (m_bus.read !== 1'b1 || m_bus.address !== 32'h3000) begin miss++; $display("FAIL tie2_lsq_wins: got r=%b a=%h want 1 00003000", m_bus.read, m_bus.address); end
        mem_respond(32'h77);
        vec++; if (l_bus.resp !== 1'b1 || l_bus.rdata !== 32'h77) begin miss++; $display("FAIL tie2_lsq_resp: got r=%b d=%h want 1 00000077", l_bus.resp, l_bus.rdata); end
        tick();
        l_bus.read = 1'b0;
        tick();
        vec++; if (m_bus.read !== 1'b1 || m_bus.address !== 32'h104) begin miss++; $display("FAIL tie2_fetch_next: got r=%b a=%h want 1 00000104", m_bus.read, m_bus.address); end
        mem_respond(32'h88);
        tick();
        i_bus.read = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        i_bus.read    = 1'b1;
        i_bus.address = 32'h104;
        tick();
        vec++; if (m_bus.read !== 1'b1) begin miss++; $display("FAIL b2b_first: got %b want 1", m_bus.read); end
        mem_respond(32'h11);
        vec++; if (i_bus.resp !== 1'b1 || m_bus.read !== 1'b0) begin miss++; $display("FAIL b2b_resp1: got resp=%b r=%b want 1 0", i_bus.resp, m_bus.read); end
        tick();
        vec++; if (m_bus.read !== 1'b0 || i_bus.resp !== 1'b0) begin miss++; $display("FAIL b2b_no_regrant: got r=%b resp=%b want 0 0", m_bus.read, i_bus.resp); end
        tick();
        vec++; if (m_bus.read !== 1'b1 || m_bus.address !== 32'h104) begin miss++; $display("FAIL b2b_second: got r=%b a=%h want 1 00000104", m_bus.read, m_bus.address); end
        mem_respond(32'h22);
        vec++; if (i_bus.resp !== 1'b1 || i_bus.rdata !== 32'h22) begin miss++; $display("FAIL b2b_resp2: got r=%b d=%h want 1 00000022", i_bus.resp, i_bus.rdata); end
        tick();
        i_bus.read = 1'b0;
        tick();
        vec++; if (m_bus.read !== 1'b0) begin miss++; $display("FAIL b2b_no_third: got %b want 0", m_bus.read); end
    endtask

    task automatic test_busy_change();
        l_bus.read        = 1'b1;
        l_bus.address     = 32'h40;
        l_bus.byte_enable = 4'hf;
        tick();
        vec++; if (m_bus.address !== 32'h40) begin miss++; $display("FAIL busy_addr0: got %h want 00000040", m_bus.address); end
        l_bus.address     = 32'h80;
        l_bus.byte_enable = 4'h1;
        tick();
        vec++; if (m_bus.address !== 32'h40 || m_bus.byte_enable !== 4'hf) begin miss++; $display("FAIL busy_hold1: got a=%h be=%h want 00000040 f", m_bus.address, m_bus.byte_enable); end
        l_bus.read = 1'b0;
        tick();
        vec++; if (m_bus.address !== 32'h40 || m_bus.read !== 1'b1) begin miss++; $display("FAIL busy_hold2: got a=%h r=%b want 00000040 1", m_bus.address, m_bus.read); end
        mem_respond(32'h55);
        vec++; if (l_bus.resp !== 1'b1 || l_bus.rdata !== 32'h55) begin miss++; $display("FAIL busy_resp: got r=%b d=%h want 1 00000055", l_bus.resp, l_bus.rdata); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        l_bus.write   = 1'b1;
        l_bus.address = 32'h500;
        l_bus.wdata   = 32'h1234;
        tick();
        vec++; if (m_bus.write !== 1'b1) begin miss++; $display("FAIL rmid_busy: got %b want 1", m_bus.write); end
        rst         = 1'b1;
        l_bus.write = 1'b0;
        tick();
        rst = 1'b0;
        vec++; if (m_bus.write !== 1'b0 || m_bus.read !== 1'b0 || m_bus.address !== 32'h0) begin miss++; $display("FAIL rmid_clear: got w=%b r=%b a=%h want 0 0 0", m_bus.write, m_bus.read, m_bus.address); end
        vec++; if (l_bus.resp !== 1'b0 || l_bus.rdata !== 32'h0) begin miss++; $display("FAIL rmid_noresp: got r=%b d=%h want 0 0", l_bus.resp, l_bus.rdata); end
        tick();
        mem_respond(32'h99);
        vec++; if (l_bus.resp !== 1'b0 || i_bus.resp !== 1'b0) begin miss++; $display("FAIL rmid_stray: got l=%b i=%b want 0 0", l_bus.resp, i_bus.resp); end
        tick();
    endtask

    task automatic test_stray();
        mem_respond(32'hFFFFFFFF);
        vec++; if (i_bus.resp !== 1'b0 || l_bus.resp !== 1'b0) begin miss++; $display("FAIL stray_resp: got i=%b l=%b want 0 0", i_bus.resp, l_bus.resp); end
        vec++; if (i_bus.rdata !== 32'h0 || l_bus.rdata !== 32'h0) begin miss++; $display("FAIL stray_rdata: got i=%h l=%h want 0 0", i_bus.rdata, l_bus.rdata); end
        vec++; if (m_bus.read !== 1'b0 || m_bus.write !== 1'b0) begin miss++; $display("FAIL stray_mem: got r=%b w=%b want 0 0", m_bus.read, m_bus.write); end
        tick();
        // Still IDLE: a fresh request must be granted immediately.
        i_bus.read    = 1'b1;
        i_bus.address = 32'h10;
        tick();
        vec++; if (m_bus.read !== 1'b1 || m_bus.address !== 32'h10) begin miss++; $display("FAIL stray_idle: got r=%b a=%h want 1 00000010", m_bus.read, m_bus.address); end
        mem_respond(32'h5);
        vec++; if (i_bus.resp !== 1'b1 || i_bus.rdata !== 32'h5) begin miss++; $display("FAIL stray_after: got r=%b d=%h want 1 00000005", i_bus.resp, i_bus.rdata); end
        tick();
        i_bus.read = 1'b0;
        tick();
    endtask

    initial begin
        vec  = 0;
        miss = 0;
        rst  = 1'b1;
        i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.byte_enable = 4'h0;
        i_bus.address = 32'h0; i_bus.wdata = 32'h0;
        l_bus.read = 1'b0; l_bus.write = 1'b0; l_bus.byte_enable = 4'h0;
        l_bus.address = 32'h0; l_bus.wdata = 32'h0;
        m_bus.resp = 1'b0; m_bus.rdata = 32'h0;
        test_reset();
        test_single_fetch();
        test_tie();
        test_back_to_back();
        test_busy_change();
        test_reset_mid();
        test_stray();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
